// File: rtl/ln_norm_sequencer.sv
// Sequences one float argument at a time through the log linearizer chain: FSM reset, begin strobe, ack wait, result capture.
// Accept-to-OUT_VALID is RST_CYCLES+2 cycles plus chain latency; IN_READY only in IDLE; optional SEQ_TIMEOUT_EN adds an ACK_FF watchdog.
module ln_norm_sequencer #(
   parameter int P          = 32,
   parameter int RST_CYCLES = 2
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = 1023
`endif
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [P-1:0] IN_T,
   input  logic         IN_VALID,
   output logic         IN_READY,
   output logic [P-1:0] T,
   output logic         RST_FSM_LN_FF,
   output logic         Begin_FSM_LN,
   input  logic         ACK_FF,
   input  logic [P-1:0] RESULT,
   output logic [P-1:0] OUT_DATA,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic         BUSY,
   output logic         TO_ERR
);

   localparam int RC_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FSM_RST,
      S_START,
      S_WAIT_ACK,
      S_OUT_HOLD,
      S_ERR
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            run_en;
   logic            accept;
   logic            capture;
   logic [RC_W-1:0] rst_cnt;

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_expire;
   logic            to_err_q;
`endif

   // Low only during reset and the first cycle after release, keeping the chain in reset meanwhile.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         run_en <= 1'b0;
      end else begin
         run_en <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      IN_READY      = 1'b0;
      RST_FSM_LN_FF = 1'b0;
      Begin_FSM_LN  = 1'b0;
      OUT_VALID     = 1'b0;
      BUSY          = (state != S_IDLE);
      accept        = 1'b0;
      capture       = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_expire     = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            IN_READY = run_en;
            accept   = run_en & IN_VALID;
            if (accept) begin
               state_nxt = S_FSM_RST;
            end
         end
         S_FSM_RST: begin
            RST_FSM_LN_FF = 1'b1;
            if (rst_cnt == '0) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            Begin_FSM_LN = 1'b1;
            state_nxt    = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (ACK_FF) begin
               capture   = 1'b1;
               state_nxt = S_OUT_HOLD;
`ifdef SEQ_TIMEOUT_EN
            end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
               wd_expire = 1'b1;
               state_nxt = S_ERR;
`endif
            end
         end
         S_OUT_HOLD: begin
            // A waiting argument is only taken after the return to IDLE.
            OUT_VALID = 1'b1;
            if (OUT_READY) begin
               state_nxt = S_IDLE;
            end
         end
`ifdef SEQ_TIMEOUT_EN
         S_ERR: begin
            RST_FSM_LN_FF = 1'b1;
            if (!IN_VALID) begin
               state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (!run_en) begin
         RST_FSM_LN_FF = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         T        <= '0;
         OUT_DATA <= '0;
         rst_cnt  <= '0;
      end else begin
         if (accept) begin
            T       <= IN_T;
            rst_cnt <= RC_W'(RST_CYCLES - 1);
         end else if (state == S_FSM_RST && rst_cnt != '0) begin
            rst_cnt <= rst_cnt - RC_W'(1);
         end
         if (capture) begin
            OUT_DATA <= RESULT;
         end
      end
   end

`ifdef SEQ_TIMEOUT_EN
   // Counts WAIT_ACK cycles; an ack on the expiry cycle still wins over the error.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wd_cnt   <= '0;
         to_err_q <= 1'b0;
      end else begin
         if (state == S_START) begin
            wd_cnt <= '0;
         end else if (state == S_WAIT_ACK) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
         if (wd_expire) begin
            to_err_q <= 1'b1;
         end
      end
   end

   assign TO_ERR = to_err_q;
`else
   assign TO_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ln_norm_sequencer.sv
// Bench for ln_norm_sequencer: behavioural chain model, result scoreboard, one task per scenario.
module tb_ln_norm_sequencer;

   localparam int P       = 32;
   localparam int RST_CYC = 2;
`ifdef SEQ_TIMEOUT_EN
   localparam int TMO     = 31;
`endif

   logic          clk;
   logic          rst;
   logic [P-1:0]  in_t;
   logic          in_valid;
   logic          in_ready;
   logic [P-1:0]  t_out;
   logic          rst_fsm;
   logic          begin_fsm;
   logic          ack_ff;
   logic [P-1:0]  result;
   logic [P-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          to_err;

   ln_norm_sequencer #(
      .P(P),
      .RST_CYCLES(RST_CYC)
`ifdef SEQ_TIMEOUT_EN
      ,
      .TIMEOUT(TMO)
`endif
   ) dut (
      .CLK(clk),
      .RST(rst),
      .IN_T(in_t),
      .IN_VALID(in_valid),
      .IN_READY(in_ready),
      .T(t_out),
      .RST_FSM_LN_FF(rst_fsm),
      .Begin_FSM_LN(begin_fsm),
      .ACK_FF(ack_ff),
      .RESULT(result),
      .OUT_DATA(out_data),
      .OUT_VALID(out_valid),
      .OUT_READY(out_ready),
      .BUSY(busy),
      .TO_ERR(to_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [P-1:0] chain_fn(input logic [P-1:0] x);
      return x ^ 32'h3F80_0000;
   endfunction

   // Chain model: acks chain_lat cycles into WAIT_ACK, ack level held until the next FSM reset.
   bit           chain_run;
   int           chain_sb;
   int           chain_lat;
   bit           chain_never;
   logic [P-1:0] chain_t;

   always @(posedge clk) begin
      if (rst_fsm) begin
         chain_run <= 1'b0;
         chain_sb  <= 0;
      end else if (begin_fsm) begin
         chain_run <= 1'b1;
         chain_sb  <= 0;
         chain_t   <= t_out;
      end else if (chain_run) begin
         chain_sb  <= chain_sb + 1;
      end
   end

   assign ack_ff = chain_run && !chain_never && (chain_sb >= chain_lat);
   assign result = ack_ff ? chain_fn(chain_t) : 32'hDEAD_BEEF;

   int           n_tests;
   int           n_fail;
   int           cyc;
   int           bgn_cnt;
   int           bgn_cyc;
   int           out_cnt;
   int           to_cyc;
   int           rst_run;
   int           last_rst_run;
   bit           ov_prev;
   bit           to_prev;
   bit           rf_prev;
   logic [P-1:0] sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [P-1:0] exp_d;
      if (begin_fsm === 1'b1) begin
         bgn_cnt++;
         bgn_cyc = cyc;
      end
      if (rst_fsm === 1'b1) begin
         rst_run++;
      end else begin
         if (rf_prev) last_rst_run = rst_run;
         rst_run = 0;
      end
      rf_prev = (rst_fsm === 1'b1);
      if (out_valid === 1'b1 && !ov_prev) begin
         n_tests++;
         if ((cyc - bgn_cyc) !== chain_lat + 2) begin
            n_fail++;
            $display("FAIL begin_to_valid latency=%0d required=%0d", cyc - bgn_cyc, chain_lat + 2);
         end
      end
      ov_prev = (out_valid === 1'b1);
      if (to_err === 1'b1 && !to_prev) to_cyc = cyc;
      to_prev = (to_err === 1'b1);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output out_data=%h required=no output", out_data);
         end else begin
            exp_d = sb.pop_front();
            if (out_data !== exp_d) begin
               n_fail++;
               $display("FAIL out_data got=%h required=%h", out_data, exp_d);
            end
         end
         out_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [P-1:0] x, input bit expect_out);
      int n = 0;
      in_t     = x;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 500) begin
         tick();
         n++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_accept arg=%h in_ready=%b required=1 within 500 cycles", x, in_ready);
      end else if (expect_out) begin
         sb.push_back(chain_fn(x));
      end
      tick();
      in_valid = 1'b0;
      in_t     = $urandom;
   endtask

   task automatic wait_out(input int target, input string name);
      int n = 0;
      while (out_cnt < target && n < 1000) begin
         tick();
         n++;
      end
      n_tests++;
      if (out_cnt !== target) begin
         n_fail++;
         $display("FAIL %s outputs=%0d required=%0d", name, out_cnt, target);
      end
   endtask

   task automatic test_reset();
      rst         = 1'b0;
      in_valid    = 1'b1;
      in_t        = 32'h4120_0000;
      out_ready   = 1'b0;
      chain_lat   = 19;
      chain_never = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({in_ready, rst_fsm, begin_fsm, out_valid, busy, to_err} !== 6'b010000) begin
         n_fail++;
         $display("FAIL reset_ctrl {rdy,rstfsm,bgn,ovld,busy,toerr}=%b required=010000",
                  {in_ready, rst_fsm, begin_fsm, out_valid, busy, to_err});
      end
      n_tests++;
      if (t_out !== 32'h0 || out_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data T=%h OUT_DATA=%h required=0/0", t_out, out_data);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({in_ready, rst_fsm, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL idle_after_reset {rdy,rstfsm,busy}=%b required=100", {in_ready, rst_fsm, busy});
      end
   endtask

   task automatic test_single();
      int b0 = bgn_cnt;
      int n  = 0;
      out_ready = 1'b0;
      chain_lat = 19;
      send(32'h3F80_0000, 1'b1);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_after_accept busy=%b required=1", busy);
      end
      while (out_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_result ovld=%b data=%h busy=%b required=1/00000000/1", out_valid, out_data, busy);
      end
      n_tests++;
      if (last_rst_run !== RST_CYC) begin
         n_fail++;
         $display("FAIL rst_fsm_width cycles=%0d required=%0d", last_rst_run, RST_CYC);
      end
      n_tests++;
      if (bgn_cnt - b0 !== 1) begin
         n_fail++;
         $display("FAIL begin_pulses count=%0d required=1", bgn_cnt - b0);
      end
   endtask

   task automatic test_backpressure();
      int b0   = bgn_cnt;
      int o0   = out_cnt;
      int viol = 0;
      in_t     = 32'h4000_0000;
      in_valid = 1'b1;
      repeat (50) begin
         tick();
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h0 || t_out !== 32'h3F80_0000) viol++;
      end
      n_tests++;
      if (viol !== 0) begin
         n_fail++;
         $display("FAIL hold_stable violations=%0d required=0", viol);
      end
      n_tests++;
      if (bgn_cnt !== b0) begin
         n_fail++;
         $display("FAIL hold_no_begin begins=%0d required=%0d", bgn_cnt, b0);
      end
      out_ready = 1'b1;
      tick();
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01 || t_out !== 32'h3F80_0000) begin
         n_fail++;
         $display("FAIL handshake_cycle {ovld,rdy}=%b T=%h required=01/3f800000", {out_valid, in_ready}, t_out);
      end
      sb.push_back(chain_fn(32'h4000_0000));
      tick();
      in_valid = 1'b0;
      n_tests++;
      if (t_out !== 32'h4000_0000 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_next T=%h busy=%b required=40000000/1", t_out, busy);
      end
      wait_out(o0 + 2, "backpressure_outputs");
   endtask

   task automatic test_back_to_back();
      logic [P-1:0] args [4];
      int b0 = bgn_cnt;
      int o0 = out_cnt;
      args[0] = 32'h4049_0FDB;
      args[1] = 32'h3F00_0000;
      args[2] = 32'hC2C8_0000;
      args[3] = 32'h0000_0001;
      out_ready = 1'b1;
      chain_lat = 19;
      for (int i = 0; i < 4; i++) send(args[i], 1'b1);
      wait_out(o0 + 4, "b2b_outputs");
      n_tests++;
      if (bgn_cnt - b0 !== 4 || sb.size() !== 0) begin
         n_fail++;
         $display("FAIL b2b_begins begins=%0d pending=%0d required=4/0", bgn_cnt - b0, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int o0 = out_cnt;
      out_ready = 1'b1;
      chain_lat = 19;
      send(32'h1234_5678, 1'b1);
      repeat (8) tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, rst_fsm, begin_fsm, out_valid, busy, to_err} !== 6'b010000 || t_out !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset {rdy,rstfsm,bgn,ovld,busy,toerr}=%b T=%h required=010000/0",
                  {in_ready, rst_fsm, begin_fsm, out_valid, busy, to_err}, t_out);
      end
      sb.delete();
      repeat (2) tick();
      rst = 1'b1;
      repeat (40) tick();
      n_tests++;
      if (out_cnt !== o0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lost_result outputs=%0d ovld=%b required=%0d/0", out_cnt, out_valid, o0);
      end
      send(32'h0BAD_F00D, 1'b1);
      wait_out(o0 + 1, "after_reset_output");
   endtask

`ifdef SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int o0 = out_cnt;
      int n  = 0;
      out_ready   = 1'b1;
      chain_never = 1'b1;
      send(32'h7F80_0000, 1'b0);
      in_t     = 32'h5555_5555;
      in_valid = 1'b1;
      while (to_err !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      n_tests++;
      if (to_err !== 1'b1 || (to_cyc - bgn_cyc) !== TMO + 1 || rst_fsm !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout toerr=%b begin_to_err=%0d rstfsm=%b required=1/%0d/1",
                  to_err, to_cyc - bgn_cyc, rst_fsm, TMO + 1);
      end
      repeat (4) tick();
      n_tests++;
      if ({busy, in_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL err_hold {busy,rdy}=%b required=10", {busy, in_ready});
      end
      in_valid = 1'b0;
      tick();
      n_tests++;
      if ({busy, to_err} !== 2'b01 || out_cnt !== o0) begin
         n_fail++;
         $display("FAIL err_exit {busy,toerr}=%b outputs=%0d required=01/%0d", {busy, to_err}, out_cnt, o0);
      end
      chain_never = 1'b0;
      chain_lat   = 19;
      send(32'h4110_0000, 1'b1);
      wait_out(o0 + 1, "post_error_output");
      n_tests++;
      if (to_err !== 1'b1) begin
         n_fail++;
         $display("FAIL to_err_sticky toerr=%b required=1", to_err);
      end
   endtask

   task automatic test_ack_at_limit();
      int o0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      o0        = out_cnt;
      chain_lat = TMO - 1;
      send(32'h3E80_0000, 1'b1);
      wait_out(o0 + 1, "ack_at_limit_output");
      n_tests++;
      if (to_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_wins toerr=%b required=0", to_err);
      end
   endtask
`else
   task automatic test_long_wait();
      int o0 = out_cnt;
      out_ready = 1'b1;
      chain_lat = 120;
      send(32'h4480_0000, 1'b1);
      wait_out(o0 + 1, "long_wait_output");
      n_tests++;
      if (to_err !== 1'b0) begin
         n_fail++;
         $display("FAIL no_watchdog toerr=%b required=0", to_err);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded, required completion");
      $fatal(1, "bench stalled");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
      test_timeout();
      test_ack_at_limit();
`else
      test_long_wait();
`endif
      n_tests++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
